// File: rtl/ps2_scancode_rx_if.sv
// PS/2 receiver bus: raw PS/2 pins in, scancode/strobes out.
// slave  = the receiver, master = whoever drives the pins and consumes codes.
interface ps2_scancode_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       valid;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  scancode, valid, parity_err, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output scancode, valid, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronises and filters the PS/2 clock,
// deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop)
// into scancodes with a one-cycle valid strobe, and flags parity/framing
// errors and inter-edge timeouts.
// Optional build macro: PS2_BREAK_FILTER_EN -- swallow 0xF0 break prefixes
// and the byte that follows them so only make codes reach the consumer.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic              clk25,
  input logic              reset,
  ps2_scancode_rx_if.slave bus
);

  localparam int              FW       = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0]   FLT_LAST = FW'(FILTER_LEN - 1);
  // Abort on the edge where the idle counter would reach TIMEOUT_CYCLES-1.
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_p0, clk_p1;
  logic          dat_p0, dat_p1;
  logic          clk_filt, clk_filt_d;
  logic [FW-1:0] flt_cnt;
  logic          fe;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [15:0]   tmo_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
`ifdef PS2_BREAK_FILTER_EN
  logic          break_pending;
`endif

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Stage p0/p1: two-flop synchronisers on the asynchronous PS/2 pins
  always_ff @(posedge clk25) begin
    if (reset) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= bus.ps2_clk;
      clk_p1 <= clk_p0;
      dat_p0 <= bus.ps2_data;
      dat_p1 <= dat_p0;
    end
  end

  // Glitch filter: follow the synchronised clock only after it has held a new level long enough
  always_ff @(posedge clk25) begin
    if (reset) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      flt_cnt    <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_p1 != clk_filt) begin
        if (flt_cnt == FLT_LAST) begin
          clk_filt <= clk_p1;
          flt_cnt  <= '0;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign fe = clk_filt_d & ~clk_filt;

  // Data capture: shift bits in LSB first and latch the parity bit (no reset, data only)
  always_ff @(posedge clk25) begin
    if (fe && state == DATA) shreg <= {dat_p1, shreg[7:1]};
    if (fe && state == PARITY) par_bit <= dat_p1;
  end

  // Frame FSM with timeout and registered scancode/strobe outputs
  always_ff @(posedge clk25) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      tmo_cnt        <= '0;
      bus.scancode   <= 8'h00;
      bus.valid      <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      break_pending  <= 1'b0;
`endif
    end else begin
      bus.valid      <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      if (state == IDLE) begin
        tmo_cnt <= '0;
        if (fe && !dat_p1) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
      end else if (fe) begin
        tmo_cnt <= '0;
        case (state)
          DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: state <= STOP;
          default: begin
            state <= IDLE;
            if (!dat_p1) begin
              bus.frame_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
              break_pending <= 1'b0;
`endif
            end else if (!odd_parity_ok(shreg, par_bit)) begin
              bus.parity_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
              break_pending  <= 1'b0;
`endif
            end else begin
`ifdef PS2_BREAK_FILTER_EN
              if (break_pending) begin
                break_pending <= 1'b0;
              end else if (shreg == 8'hF0) begin
                break_pending <= 1'b1;
              end else begin
                bus.scancode <= shreg;
                bus.valid    <= 1'b1;
              end
`else
              bus.scancode <= shreg;
              bus.valid    <= 1'b1;
`endif
            end
          end
        endcase
      end else if (tmo_cnt == TMO_LAST) begin
        state         <= IDLE;
        tmo_cnt       <= '0;
        bus.frame_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
        break_pending <= 1'b0;
`endif
      end else begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Testbench for ps2_scancode_rx: drives PS/2 frames bit by bit and compares
// strobes, their timing and the held scancode against a frame-level model.
module tb_ps2_scancode_rx;

  localparam int FL  = 8;
  localparam int TO  = 1000;
  localparam int H   = 40;       // PS/2 half-period in clk25 cycles
  localparam int LAT = FL + 3;   // pin falling edge -> strobe visible (sync 2 + filter + edge)

  logic clk25 = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   multi_cnt = 0;

  typedef struct { int kind; int cyc; } ev_t;  // kind: 1 valid, 2 parity_err, 3 frame_err
  ev_t evq[$];

  logic [7:0] m_sc  = 8'h00;
  bit         m_brk = 1'b0;

  ps2_scancode_rx_if bif ();

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk25 (clk25),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk25 = ~clk25;
  always @(posedge clk25) cyc <= cyc + 1;

  always @(negedge clk25) begin : mon
    ev_t e;
    if (!reset && (bif.valid || bif.parity_err || bif.frame_err)) begin
      e.kind = bif.valid ? 1 : (bif.parity_err ? 2 : 3);
      e.cyc  = cyc;
      evq.push_back(e);
      if (int'(bif.valid) + int'(bif.parity_err) + int'(bif.frame_err) > 1) multi_cnt++;
    end
  end

  // Frame-level reference: outcome of one complete frame; 0 = nothing reported
  function automatic int model_frame(input logic [7:0] d, input bit p, input bit s);
    int ones = $countones({d, p});
    if (!s) begin m_brk = 1'b0; return 3; end
    if (ones % 2 == 0) begin m_brk = 1'b0; return 2; end
`ifdef PS2_BREAK_FILTER_EN
    if (m_brk) begin m_brk = 1'b0; return 0; end
    if (d == 8'hF0) begin m_brk = 1'b1; return 0; end
`endif
    m_sc = d;
    return 1;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at,
                           output int last_drop);
    last_drop = 0;
    for (int i = 0; i < nbits; i++) begin
      bif.ps2_data = bits[i];
      wait_cyc(H / 2);
      if (i == glitch_at) begin
        bif.ps2_clk = 1'b0;
        wait_cyc(3);
        bif.ps2_clk = 1'b1;
      end
      wait_cyc(H / 2);
      bif.ps2_clk = 1'b0;
      last_drop   = cyc;
      wait_cyc(H);
      bif.ps2_clk = 1'b1;
    end
    wait_cyc(2);
    bif.ps2_data = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] d, input bit p, input bit s, input int glitch_at,
                           output int n_ev, output int kind, output int lat, output logic [7:0] sc);
    int last;
    evq.delete();
    send_bits({s, p, d, 1'b0}, 11, glitch_at, last);
    wait_cyc(4);
    n_ev = evq.size();
    kind = 0;
    lat  = -1;
    sc   = bif.scancode;
    if (n_ev > 0) begin
      kind = evq[0].kind;
      lat  = evq[0].cyc - last;
    end
  endtask

  task automatic test_reset;
    bif.ps2_clk  = 1'b1;
    bif.ps2_data = 1'b1;
    reset = 1'b1;
    wait_cyc(5);
    checks++; if (bif.scancode !== 8'h00) begin errors++; $display("FAIL reset_scancode: got %h want 00", bif.scancode); end
    checks++; if (bif.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bif.valid); end
    checks++; if (bif.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", bif.parity_err); end
    checks++; if (bif.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", bif.frame_err); end
    reset = 1'b0;
    evq.delete();
    wait_cyc(30);
    checks++; if (evq.size() != 0) begin errors++; $display("FAIL reset_idle_quiet: got %0d strobes want 0", evq.size()); end
  endtask

  // Directed frames: good 0x16, bad parity 0x1E, bad stop 0x26, good 0x25
  task automatic test_known_frames;
    logic [7:0] td [4] = '{8'h16, 8'h1E, 8'h26, 8'h25};
    bit         tp [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    bit         ts [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int n, k, l, exp;
    logic [7:0] sc;
    for (int i = 0; i < 4; i++) begin
      run_frame(td[i], tp[i], ts[i], -1, n, k, l, sc);
      exp = model_frame(td[i], tp[i], ts[i]);
      checks++; if (n != (exp == 0 ? 0 : 1)) begin errors++; $display("FAIL known_count[%0d]: got %0d strobes want %0d", i, n, (exp == 0 ? 0 : 1)); end
      if (exp != 0) begin
        checks++; if (k != exp) begin errors++; $display("FAIL known_kind[%0d]: got %0d want %0d", i, k, exp); end
        checks++; if (l != LAT) begin errors++; $display("FAIL known_latency[%0d]: got %0d want %0d", i, l, LAT); end
      end
      checks++; if (sc !== m_sc) begin errors++; $display("FAIL known_scancode[%0d]: got %h want %h", i, sc, m_sc); end
    end
  endtask

  task automatic test_timeout;
    int last, n, k, l, exp;
    logic [7:0] sc;
    evq.delete();
    send_bits({2'b11, 8'h26, 1'b0}, 4, -1, last);
    while (evq.size() == 0 && cyc < last + LAT + TO + 20) wait_cyc(1);
    m_brk = 1'b0;
    checks++; if (evq.size() != 1) begin errors++; $display("FAIL timeout_count: got %0d strobes want 1", evq.size()); end
    if (evq.size() > 0) begin
      checks++; if (evq[0].kind != 3) begin errors++; $display("FAIL timeout_kind: got %0d want 3", evq[0].kind); end
      checks++; if (evq[0].cyc - last != LAT - 1 + TO) begin errors++; $display("FAIL timeout_delay: got %0d want %0d", evq[0].cyc - last, LAT - 1 + TO); end
    end
    run_frame(8'h26, 1'b0, 1'b1, -1, n, k, l, sc);
    exp = model_frame(8'h26, 1'b0, 1'b1);
    checks++; if (n != 1 || k != exp || l != LAT) begin errors++; $display("FAIL timeout_recover: got n=%0d kind=%0d lat=%0d want n=1 kind=%0d lat=%0d", n, k, l, exp, LAT); end
    checks++; if (sc !== m_sc) begin errors++; $display("FAIL timeout_recover_scancode: got %h want %h", sc, m_sc); end
  endtask

  task automatic test_glitch;
    int n, k, l, exp;
    logic [7:0] sc;
    evq.delete();
    bif.ps2_data = 1'b0;
    bif.ps2_clk  = 1'b0;
    wait_cyc(3);
    bif.ps2_clk  = 1'b1;
    wait_cyc(30);
    bif.ps2_data = 1'b1;
    checks++; if (evq.size() != 0) begin errors++; $display("FAIL glitch_idle: got %0d strobes want 0", evq.size()); end
    run_frame(8'h1E, 1'b1, 1'b1, 4, n, k, l, sc);
    exp = model_frame(8'h1E, 1'b1, 1'b1);
    checks++; if (n != 1 || k != exp || l != LAT) begin errors++; $display("FAIL glitch_data: got n=%0d kind=%0d lat=%0d want n=1 kind=%0d lat=%0d", n, k, l, exp, LAT); end
    checks++; if (sc !== m_sc) begin errors++; $display("FAIL glitch_scancode: got %h want %h", sc, m_sc); end
  endtask

  task automatic test_break_seq;
    logic [7:0] td [3] = '{8'h1E, 8'hF0, 8'h1E};
    int n, k, l, exp, nvalid;
    logic [7:0] sc;
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin
      run_frame(td[i], 1'b1, 1'b1, -1, n, k, l, sc);
      exp = model_frame(td[i], 1'b1, 1'b1);
      if (exp == 1) nvalid++;
      checks++; if (n != (exp == 0 ? 0 : 1) || (exp != 0 && (k != exp || l != LAT))) begin errors++; $display("FAIL break_frame[%0d]: got n=%0d kind=%0d lat=%0d want kind=%0d", i, n, k, l, exp); end
      checks++; if (sc !== m_sc) begin errors++; $display("FAIL break_scancode[%0d]: got %h want %h", i, sc, m_sc); end
    end
`ifdef PS2_BREAK_FILTER_EN
    checks++; if (nvalid != 1) begin errors++; $display("FAIL break_valid_total: got %0d want 1", nvalid); end
`else
    checks++; if (nvalid != 3) begin errors++; $display("FAIL break_valid_total: got %0d want 3", nvalid); end
`endif
  endtask

  task automatic test_reset_mid_frame;
    int last;
    send_bits({2'b11, 8'h5A, 1'b0}, 4, -1, last);
    reset = 1'b1;
    wait_cyc(1);
    m_sc  = 8'h00;
    m_brk = 1'b0;
    checks++; if (bif.scancode !== 8'h00) begin errors++; $display("FAIL midreset_scancode: got %h want 00", bif.scancode); end
    checks++; if ({bif.valid, bif.parity_err, bif.frame_err} !== 3'b000) begin errors++; $display("FAIL midreset_strobes: got %b want 000", {bif.valid, bif.parity_err, bif.frame_err}); end
    reset = 1'b0;
    evq.delete();
    wait_cyc(TO + 50);
    checks++; if (evq.size() != 0) begin errors++; $display("FAIL midreset_quiet: got %0d strobes want 0", evq.size()); end
  endtask

  task automatic test_random;
    int n, k, l, exp;
    logic [7:0] sc, d;
    bit p, s;
    for (int i = 0; i < 14; i++) begin
      d = ($urandom_range(0, 4) == 0) ? 8'hF0 : 8'($urandom_range(0, 255));
      p = ~(^d);
      if ($urandom_range(0, 3) == 0) p = ~p;
      s = ($urandom_range(0, 7) != 0);
      run_frame(d, p, s, -1, n, k, l, sc);
      exp = model_frame(d, p, s);
      checks++; if (n != (exp == 0 ? 0 : 1) || (exp != 0 && (k != exp || l != LAT))) begin errors++; $display("FAIL random[%0d] d=%h p=%0d s=%0d: got n=%0d kind=%0d lat=%0d want kind=%0d", i, d, p, s, n, k, l, exp); end
      checks++; if (sc !== m_sc) begin errors++; $display("FAIL random_scancode[%0d]: got %h want %h", i, sc, m_sc); end
    end
  endtask

  initial begin
    bif.ps2_clk  = 1'b1;
    bif.ps2_data = 1'b1;
    test_reset();
    test_known_frames();
    test_timeout();
    test_glitch();
    test_break_seq();
    test_reset_mid_frame();
    test_random();
    checks++; if (multi_cnt != 0) begin errors++; $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", multi_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
